id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Registered, parametrised instruction-decode stage sitting between fetch and execute, with valid/ready handshakes on both sides.
- Splits the instruction into fields and drives register-file read addresses combinationally.
- Generates sign-extended immediates for all RV32I formats (I, S, B, U, J).
- Flags illegal encodings.
- Inserts a one-cycle bubble on load-use hazards.
- Captures the decoded bundle in an ID/EX pipeline register, with synchronous flush for branch/jump redirects.

Parameters:
XLEN, 32, data/immediate/PC width (32 for RV32I; 64 only widens sign extension).
REG_AW, 5, register address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage accepts the instruction this cycle.
in_pc  in  XLEN  PC of the presented instruction.
in_instr  in  32  presented instruction.
rs1_addr  out  REG_AW  combinational in_instr[19:15], to regfile.
rs2_addr  out  REG_AW  combinational in_instr[24:20], to regfile.
rs1_data  in  XLEN  regfile read data for rs1_addr, same cycle.
rs2_data  in  XLEN  regfile read data for rs2_addr, same cycle.
flush  in  1  kill the instruction in ID and the one being presented.
out_valid  out  1  registered bundle valid.
out_ready  in  1  execute accepts the bundle.
out_pc  out  XLEN  registered PC.
out_rs1_val, out_rs2_val  out  XLEN  registered operand data.
out_imm  out  XLEN  registered sign-extended immediate.
out_rs1, out_rs2, out_rd  out  REG_AW  registered register addresses.
out_opcode  out  7  registered opcode.
out_funct3  out  3  registered funct3.
out_funct7  out  7  registered funct7.
out_fmt  out  3  registered format code (pkg enum).
out_is_load  out  1  registered: opcode is LOAD.
out_illegal  out  1  registered: unrecognised encoding.

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including out_valid, out_illegal and out_is_load.
- Latency: exactly 1 cycle from accepted input to out_valid.
- Hold condition: hold = out_valid && !out_ready.
- Load-use hazard: hazard = in_valid && out_valid && out_is_load && out_rd != 0, and one of:
  - uses_rs1 && rs1_addr == out_rd
  - uses_rs2 && rs2_addr == out_rd
- uses_rs1 is true for R, I, S, B formats. uses_rs2 is true for R, S, B formats. U and J use neither.
- in_ready = !flush && !hold && !hazard (combinational).
- Register update, in priority order each edge:
  1. flush: out_valid <= 0. Input is not accepted.
  2. hold: all outputs keep their value.
  3. hazard, with out_ready=1: out_valid <= 0 (bubble). Input stays presented; accepted next cycle.
  4. in_valid && in_ready: load the full decoded bundle; out_valid <= 1.
  5. Otherwise (out_ready && !in_valid): out_valid <= 0.
- Payload registers need only update on load. Bubble and flush clear only out_valid.
- Immediates (sign bit is instr[31], replicated to XLEN):
  - I (OP-IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011, MISC-MEM 0001111): instr[31:20].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (LUI 0110111, AUIPC 0010111): {instr[31:12], 12'b0}, sign-extended above bit 31.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R (0110011): imm = 0.
- Illegal: instr[1:0] != 2'b11, or opcode outside the list above. Then out_illegal=1, out_fmt=FMT_R, imm=0, and both uses_* flags are 0 (no hazard stall).
- Illegal instructions still propagate with out_valid=1; the exception is raised downstream.
- Reset deasserted mid-stream: no spurious out_valid in the first cycle.

Decomposition:
- Package id_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, ...).
  - format enum FMT_R/I/S/B/U/J (3 bits).
  - function imm_gen(instr, fmt) returning XLEN.
- One natural combinational sub-module: id_decode. It produces fmt, imm, uses_rs1, uses_rs2, is_load and illegal from in_instr.
- id_stage_pipe contains the hazard logic, handshake logic and pipeline register.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=1, out_fmt=I.
- beq x0,x0,-4 (0xFE000EE3) → out_imm=0xFFFFFFFC. lui x5,0x12345 (0x123452B7) → out_imm=0x12345000. jal x1,+2048 (0x001000EF) → out_imm=0x00000800.
- lw x3,0(x2) (0x00012183) then add x4,x3,x1 (0x00118233) back-to-back → one cycle with in_ready=0 and out_valid=0 (bubble), then add issues. Repeat with lw rd=x0 → no bubble.
- Backpressure: out_ready=0 for 3 cycles with a valid bundle → outputs stable, in_ready=0. out_ready=1 → next input accepted that cycle.
- flush asserted with out_valid=1 and in_valid=1 → next cycle out_valid=0, input not consumed (in_ready=0 during flush).
- Instruction 0x00000000 (bits[1:0]=00) → out_illegal=1, out_imm=0, no hazard stall. Asserting rst_n=0 mid-stream → out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - RV32I decode constants, format enum and immediate generator
//
// Package id_pkg: opcode constants, instruction format codes and imm_gen().
// imm_gen always returns the 32-bit RV32I immediate, already sign-extended to
// bit 31. Callers that need a wider XLEN sign-extend the result further.
package id_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input fmt_e fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - fetch/regfile/execute handshake bundle of the decode stage
//
// slave  : the decode stage (consumes in_*, rs*_data, flush, out_ready;
//          drives in_ready, rs*_addr and the registered out_* bundle).
// master : the surrounding pipeline (fetch, regfile, execute, redirect logic).
interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rs1_val;
    logic [XLEN-1:0]   out_rs2_val;
    logic [XLEN-1:0]   out_imm;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [2:0]        out_fmt;
    logic              out_is_load;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, rs1_data, rs2_data, flush, out_ready,
        output in_ready, rs1_addr, rs2_addr,
        output out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
        output out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7,
        output out_fmt, out_is_load, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr,
        input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
        input  out_rs1, out_rs2, out_rd, out_opcode, out_funct3, out_funct7,
        input  out_fmt, out_is_load, out_illegal
    );
endinterface

// File: rtl/id_stage_pipe_decode.sv
// rtl/id_stage_pipe_decode.sv - combinational RV32I field classifier and immediate extender
//
// Module id_decode
//   instr    in  32    instruction being presented by fetch
//   fmt      out       format code (FMT_R for illegal encodings)
//   imm      out XLEN  sign-extended immediate (0 for R and illegal)
//   uses_rs1 out 1     instruction reads rs1 (R/I/S/B)
//   uses_rs2 out 1     instruction reads rs2 (R/S/B)
//   is_load  out 1     opcode is LOAD
//   illegal  out 1     unrecognised encoding
module id_decode
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            is_load,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [31:0] imm32;

    assign opcode = instr[6:0];

    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        is_load = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP:       fmt = FMT_R;
                OPC_LOAD: begin
                    fmt     = FMT_I;
                    is_load = 1'b1;
                end
                OPC_OP_IMM,
                OPC_JALR,
                OPC_SYSTEM,
                OPC_MISC_MEM: fmt = FMT_I;
                OPC_STORE:    fmt = FMT_S;
                OPC_BRANCH:   fmt = FMT_B;
                OPC_LUI,
                OPC_AUIPC:    fmt = FMT_U;
                OPC_JAL:      fmt = FMT_J;
                default:      illegal = 1'b1;
            endcase
        end
    end

    // Illegal encodings never request operands, so they can never stall on a load.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (!illegal) begin
            uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
            uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        end
    end

    always_comb begin
        imm32 = '0;
        if (!illegal) begin
            imm32 = imm_gen(instr, fmt);
        end
    end

    // Signed size cast widens past bit 31 when XLEN > 32.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV32I decode stage with load-use bubble and flush
//
// Module id_stage_pipe
//   clk    in  1   clock, rising edge
//   rst_n  in  1   asynchronous active-low reset, clears every registered output
//   bus    slave modport of id_stage_pipe_if:
//          fetch side   in_valid/in_ready/in_pc/in_instr
//          regfile      rs1_addr/rs2_addr (combinational), rs1_data/rs2_data
//          redirect     flush
//          execute side out_valid/out_ready and the registered out_* bundle
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    id_stage_pipe_if.slave bus
);

    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_uses_rs1;
    logic            dec_uses_rs2;
    logic            dec_is_load;
    logic            dec_illegal;

    id_decode #(.XLEN(XLEN)) u_decode (
        .instr    (bus.in_instr),
        .fmt      (dec_fmt),
        .imm      (dec_imm),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .is_load  (dec_is_load),
        .illegal  (dec_illegal)
    );

    logic              valid_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_val_q;
    logic [XLEN-1:0]   rs2_val_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic [6:0]        opcode_q;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;
    fmt_e              fmt_q;
    logic              is_load_q;
    logic              illegal_q;

    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic              hold;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              hazard;
    logic              in_ready;
    logic              accept;

    assign rs1_addr = REG_AW'(bus.in_instr[19:15]);
    assign rs2_addr = REG_AW'(bus.in_instr[24:20]);

    assign hold = valid_q && !bus.out_ready;

    // The load in ID/EX has not produced its data yet; a dependent consumer
    // must wait one cycle. x0 is never a real dependency.
    assign rs1_hit = dec_uses_rs1 && (rs1_addr == rd_q);
    assign rs2_hit = dec_uses_rs2 && (rs2_addr == rd_q);
    assign hazard  = bus.in_valid && valid_q && is_load_q && (rd_q != '0) && (rs1_hit || rs2_hit);

    assign in_ready = !bus.flush && !hold && !hazard;
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            fmt_q     <= FMT_R;
            is_load_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (!hold) begin
                // Covers bubble (hazard), accept and idle drain in one place;
                // accept is already false under a hazard.
                valid_q <= accept;
            end

            // Payload only moves on accept; bubbles and flushes leave it alone.
            if (accept) begin
                pc_q      <= bus.in_pc;
                rs1_val_q <= bus.rs1_data;
                rs2_val_q <= bus.rs2_data;
                imm_q     <= dec_imm;
                rs1_q     <= rs1_addr;
                rs2_q     <= rs2_addr;
                rd_q      <= REG_AW'(bus.in_instr[11:7]);
                opcode_q  <= bus.in_instr[6:0];
                funct3_q  <= bus.in_instr[14:12];
                funct7_q  <= bus.in_instr[31:25];
                fmt_q     <= dec_fmt;
                is_load_q <= dec_is_load;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.rs1_addr    = rs1_addr;
    assign bus.rs2_addr    = rs2_addr;
    assign bus.out_valid   = valid_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_rs1_val = rs1_val_q;
    assign bus.out_rs2_val = rs2_val_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_rs1     = rs1_q;
    assign bus.out_rs2     = rs2_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_opcode  = opcode_q;
    assign bus.out_funct3  = funct3_q;
    assign bus.out_funct7  = funct7_q;
    assign bus.out_fmt     = fmt_q;
    assign bus.out_is_load = is_load_q;
    assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .REG_AW(5)) bus ();

    id_stage_pipe #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_instr = ins;
    endtask

    initial begin
        rst_n         = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        bus.rs1_data  = 32'h0;
        bus.rs2_data  = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Asynchronous reset, checked before the first clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid",   bus.out_valid,   0);
        chk("rst_out_illegal", bus.out_illegal, 0);
        chk("rst_out_is_load", bus.out_is_load, 0);
        chk("rst_out_imm",     bus.out_imm,     0);
        chk("rst_out_rd",      bus.out_rd,      0);
        chk("rst_out_pc",      bus.out_pc,      0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_out_valid", bus.out_valid, 0);

        // addi x1,x0,-1
        drive(1'b1, 32'h100, 32'hFFF00093);
        #1;
        chk("addi_in_ready", bus.in_ready, 1);
        chk("addi_rs1_addr", bus.rs1_addr, 0);
        chk("addi_rs2_addr", bus.rs2_addr, 31);
        step();
        chk("addi_out_valid", bus.out_valid, 1);
        chk("addi_out_imm",   bus.out_imm,   32'hFFFFFFFF);
        chk("addi_out_rd",    bus.out_rd,    1);
        chk("addi_out_fmt",   bus.out_fmt,   1);
        chk("addi_out_pc",    bus.out_pc,    32'h100);

        // beq x0,x0,-4
        drive(1'b1, 32'h104, 32'hFE000EE3);
        step();
        chk("beq_out_imm", bus.out_imm, 32'hFFFFFFFC);
        chk("beq_out_fmt", bus.out_fmt, 3);

        // lui x5,0x12345
        drive(1'b1, 32'h108, 32'h123452B7);
        step();
        chk("lui_out_imm", bus.out_imm, 32'h12345000);
        chk("lui_out_rd",  bus.out_rd,  5);
        chk("lui_out_fmt", bus.out_fmt, 4);

        // jal x1,+2048
        drive(1'b1, 32'h10C, 32'h001000EF);
        step();
        chk("jal_out_imm", bus.out_imm, 32'h00000800);
        chk("jal_out_fmt", bus.out_fmt, 5);

        // sw x5,-4(x1)
        drive(1'b1, 32'h110, 32'hFE50AE23);
        step();
        chk("sw_out_imm", bus.out_imm, 32'hFFFFFFFC);
        chk("sw_out_fmt", bus.out_fmt, 2);
        chk("sw_out_rs2", bus.out_rs2, 5);

        // lw x3,0(x2) then add x4,x3,x1: one bubble.
        drive(1'b1, 32'h140, 32'h00012183);
        step();
        chk("lw_out_is_load", bus.out_is_load, 1);
        chk("lw_out_rd",      bus.out_rd,      3);
        drive(1'b1, 32'h144, 32'h00118233);
        bus.rs1_data = 32'h11110003;
        bus.rs2_data = 32'h22220001;
        #1;
        chk("lu_rs1_addr", bus.rs1_addr, 3);
        chk("lu_in_ready_stall", bus.in_ready, 0);
        step();
        chk("lu_bubble_valid", bus.out_valid, 0);
        chk("lu_in_ready_after", bus.in_ready, 1);
        step();
        chk("lu_add_valid",   bus.out_valid,   1);
        chk("lu_add_rd",      bus.out_rd,      4);
        chk("lu_add_pc",      bus.out_pc,      32'h144);
        chk("lu_add_rs1_val", bus.out_rs1_val, 32'h11110003);
        chk("lu_add_rs2_val", bus.out_rs2_val, 32'h22220001);
        chk("lu_add_opcode",  bus.out_opcode,  7'h33);
        chk("lu_add_is_load", bus.out_is_load, 0);

        // lw x0 then add x4,x0,x1: no bubble.
        drive(1'b1, 32'h148, 32'h00012003);
        step();
        chk("lw0_out_rd", bus.out_rd, 0);
        drive(1'b1, 32'h14C, 32'h00100233);
        #1;
        chk("lw0_in_ready", bus.in_ready, 1);
        step();
        chk("lw0_add_valid", bus.out_valid, 1);
        chk("lw0_add_rd",    bus.out_rd,    4);

        // Backpressure for three cycles.
        drive(1'b1, 32'h200, 32'hFFF00093);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_in_ready_0", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_rd",    bus.out_rd,    4);
            chk("bp_hold_pc",    bus.out_pc,    32'h14C);
            chk("bp_in_ready",   bus.in_ready,  0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1);
        step();
        chk("bp_next_rd", bus.out_rd, 1);
        chk("bp_next_pc", bus.out_pc, 32'h200);

        // Flush with a valid bundle and a presented instruction.
        drive(1'b1, 32'h300, 32'h123452B7);
        bus.flush = 1'b1;
        #1;
        chk("fl_in_ready", bus.in_ready, 0);
        step();
        chk("fl_out_valid", bus.out_valid, 0);
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("fl_not_consumed", bus.out_valid, 0);
        chk("fl_payload_kept", bus.out_imm,   32'hFFFFFFFF);

        // Illegal encoding after a load: rs1 field matches rd, yet no stall.
        drive(1'b1, 32'h400, 32'h00012183);
        step();
        drive(1'b1, 32'h404, 32'h00018000);
        #1;
        chk("ill_in_ready", bus.in_ready, 1);
        step();
        chk("ill_out_valid",   bus.out_valid,   1);
        chk("ill_out_illegal", bus.out_illegal, 1);
        chk("ill_out_imm",     bus.out_imm,     0);
        chk("ill_out_fmt",     bus.out_fmt,     0);
        chk("ill_out_is_load", bus.out_is_load, 0);
        drive(1'b1, 32'h408, 32'h0000007F);
        step();
        chk("ill_opc_illegal", bus.out_illegal, 1);
        drive(1'b1, 32'h40C, 32'hFFF00093);
        step();
        chk("legal_again", bus.out_illegal, 0);
        chk("legal_valid", bus.out_valid,   1);

        // Reset asserted mid-stream, between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_imm",   bus.out_imm,   0);
        chk("mid_rst_rd",    bus.out_rd,    0);
        drive(1'b0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", bus.out_valid, 0);
        drive(1'b1, 32'h500, 32'h001000EF);
        step();
        chk("post_rst_resume", bus.out_valid, 1);
        chk("post_rst_imm",    bus.out_imm,   32'h00000800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
